// File: rtl/usbls_pkg.sv
// Shared definitions for the low-speed USB receive path: PID flag
// encodings, CRC16 constants, packet-check FSM states and the CRC step.
package usbls_pkg;

    // One-hot PID flags as delivered by the receiver front end
    localparam logic [3:0] PID_DATA0 = 4'b1000;
    localparam logic [3:0] PID_DATA1 = 4'b0100;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b0001;

    localparam logic [3:0] PID_DATA_MASK = PID_DATA0 | PID_DATA1;
    localparam logic [3:0] PID_HS_MASK   = PID_ACK | PID_NAK;

    // USB CRC16: x^16 + x^15 + x^2 + 1, MSB-first register form
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } rx_state_e;

    // Advance the CRC register by one serial bit
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic        bit_in,
                                               input logic [15:0] poly);
        return {crc[14:0], 1'b0} ^ ((bit_in ^ crc[15]) ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/usbls_crc16_serial.sv
// Bit-serial CRC16 register: init reloads the seed, enable shifts in bit_in.
module usbls_crc16_serial
    import usbls_pkg::*;
#(
    parameter logic [15:0] POLY = CRC16_POLY,
    parameter logic [15:0] INIT = CRC16_INIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q;

    // CRC register: seed on reset/init, one polynomial step per enabled cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= INIT;
        end else if (init) begin
            crc_q <= INIT;
        end else if (enable) begin
            crc_q <= crc16_step(crc_q, bit_in, POLY);
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/usbls_rx_pkt_check.sv
// Packet checker behind the low-speed USB receiver. Latches each completed
// DATA0/DATA1 packet, runs the CRC16 serially over payload plus CRC field,
// and reports a verdict; ACK/NAK handshakes are forwarded as single pulses.
module usbls_rx_pkt_check
    import usbls_pkg::*;
#(
    parameter int unsigned MAX_BYTES    = 8,
    parameter logic [15:0] CRC_POLY     = CRC16_POLY,
    parameter logic [15:0] CRC_RESIDUAL = CRC16_RESIDUAL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  pid_flag,
    input  logic [63:0] data,
    input  logic [15:0] crcdata,
    input  logic [3:0]  byte_size,
    input  logic        receive_complete,
    output logic        pkt_valid,
    output logic        pkt_crc_ok,
    output logic        pkt_len_err,
    output logic        pkt_data1,
    output logic [3:0]  pkt_len,
    output logic [63:0] pkt_data,
    output logic        hs_valid,
    output logic        hs_ack,
    output logic        hs_nak,
    output logic        busy,
    output logic        overrun
);

    localparam logic [4:0] MAX_LEN = 5'(MAX_BYTES);

    rx_state_e   state_q, state_d;

    logic        rc_q;
    logic [3:0]  hs_q;
    logic [3:0]  hs_now;
    logic        rc_rise, new_pkt, capture, len_over, hs_rise;

    logic [63:0] cap_data;
    logic [15:0] cap_crc;
    logic [3:0]  cap_len;
    logic        cap_data1;
    logic        len_err_q;

    logic [6:0]  bit_idx;
    logic [6:0]  payload_bits;
    logic [6:0]  last_idx;
    logic [5:0]  data_pos;
    logic [3:0]  crc_pos;
    logic        bit_sel;

    logic        crc_init, crc_en, pkt_fire;
    logic [15:0] crc_val;

    assign hs_now   = pid_flag & PID_HS_MASK;
    assign rc_rise  = receive_complete & ~rc_q;
    assign new_pkt  = rc_rise & (|(pid_flag & PID_DATA_MASK));
    assign capture  = new_pkt & (state_q == ST_IDLE);
    assign len_over = {1'b0, byte_size} > MAX_LEN;
    assign hs_rise  = (|hs_now) & ~(|hs_q);

    // Edge detectors for receive_complete and the handshake flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rc_q <= 1'b0;
            hs_q <= '0;
        end else begin
            rc_q <= receive_complete;
            hs_q <= hs_now;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: oversize packets skip the CRC pass entirely
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (capture) state_d = len_over ? ST_DONE : ST_CALC;
            ST_CALC: if (bit_idx == last_idx) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: CRC control, busy flag and result strobe
    always_comb begin
        crc_init = capture;
        crc_en   = 1'b0;
        pkt_fire = 1'b0;
        unique case (state_q)
            ST_CALC: crc_en   = 1'b1;
            ST_DONE: pkt_fire = 1'b1;
            default: ;
        endcase
        busy = crc_en;
    end

    // Capture registers and serial bit counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_data  <= '0;
            cap_crc   <= '0;
            cap_len   <= '0;
            cap_data1 <= 1'b0;
            len_err_q <= 1'b0;
            bit_idx   <= '0;
        end else if (capture) begin
            cap_data  <= data;
            cap_crc   <= crcdata;
            cap_len   <= byte_size;
            cap_data1 <= |(pid_flag & PID_DATA1);
            len_err_q <= len_over;
            bit_idx   <= '0;
        end else if (state_q == ST_CALC) begin
            bit_idx   <= bit_idx + 7'd1;
        end
    end

    // Bit mux: payload bytes (LSB first, byte0 at [63:56]) then CRC field.
    // payload_bits is a multiple of 8, so the CRC offset only needs the low
    // nibble of the counter.
    always_comb begin
        payload_bits = {cap_len, 3'b000};
        last_idx     = payload_bits + 7'd15;
        data_pos     = 6'd56 - {bit_idx[5:3], 3'b000} + {3'b000, bit_idx[2:0]};
        crc_pos      = bit_idx[3:0] - {cap_len[0], 3'b000};
        bit_sel      = (bit_idx < payload_bits) ? cap_data[data_pos] : cap_crc[crc_pos];
    end

    usbls_crc16_serial #(
        .POLY (CRC_POLY),
        .INIT (CRC16_INIT)
    ) u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .init    (crc_init),
        .enable  (crc_en),
        .bit_in  (bit_sel),
        .crc_out (crc_val)
    );

    // Packet result registers: refreshed only on the DONE cycle, held otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_valid   <= 1'b0;
            pkt_crc_ok  <= 1'b0;
            pkt_len_err <= 1'b0;
            pkt_data1   <= 1'b0;
            pkt_len     <= '0;
            pkt_data    <= '0;
        end else begin
            pkt_valid <= pkt_fire;
            if (pkt_fire) begin
                pkt_crc_ok  <= (crc_val == CRC_RESIDUAL) & ~len_err_q;
                pkt_len_err <= len_err_q;
                pkt_data1   <= cap_data1;
                pkt_len     <= cap_len;
                pkt_data    <= cap_data;
            end
        end
    end

    // Single-cycle event pulses: handshake detection and dropped-packet overrun
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_valid <= 1'b0;
            hs_ack   <= 1'b0;
            hs_nak   <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            hs_valid <= hs_rise;
            hs_ack   <= hs_rise & (|(pid_flag & PID_ACK));
            hs_nak   <= hs_rise & (|(pid_flag & PID_NAK));
            overrun  <= new_pkt & (state_q != ST_IDLE);
        end
    end

endmodule
